// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// The word width default here must track the FIFO's own data width.
package fifo_wr_arbiter_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int MAX_REQ         = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] index);
        logic [MAX_REQ-1:0] vec;
        vec        = '0;
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter: requests and data in, grant and FIFO write out.
interface fifo_wr_arbiter_if
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          busy;

    modport master (
        output req, req_data, full,
        input  gnt, ack, w_en, data_in, busy
    );

    modport slave (
        input  req, req_data, full,
        output gnt, ack, w_en, data_in, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last_i+1 upward with wrap,
// so the previous owner is considered last.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   winner_o
);

    logic [IDX_W:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = {1'b0, last_i} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (req_i[idx[IDX_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between NUM_REQ producers: round-robin grant,
// burst locking up to MAX_BURST accepted words, and stalls while the FIFO is full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 busy_q;
    logic [IDX_W-1:0]     last_owner_q;
    logic [CNT_WIDTH-1:0] burst_cnt_q;

    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    logic                  owning;
    logic                  w_en;
    logic                  burst_last;
    logic                  release_ev;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_winner;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // While a grant is held, last_owner_q is the current owner.
    assign owning     = |gnt_q;
    assign w_en       = owning & bus.req[last_owner_q] & ~bus.full;
    assign burst_last = (burst_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
    assign release_ev = owning & (~bus.req[last_owner_q] | (w_en & burst_last));

    // An owner that still requests is searched last, so it is regranted only when alone.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (bus.req),
        .last_i   (last_owner_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.w_en    = w_en;
    assign bus.ack     = w_en ? gnt_q : '0;
    assign bus.data_in = owning ? req_data_arr[last_owner_q] : '0;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state_q      <= ARB_OWN;
                        gnt_q        <= NUM_REQ'(onehot(3'(pick_winner)));
                        busy_q       <= 1'b1;
                        last_owner_q <= pick_winner;
                        burst_cnt_q  <= '0;
                    end
                end
                ARB_OWN: begin
                    if (release_ev) begin
                        if (pick_found) begin
                            gnt_q        <= NUM_REQ'(onehot(3'(pick_winner)));
                            last_owner_q <= pick_winner;
                            burst_cnt_q  <= '0;
                        end else begin
                            state_q     <= ARB_IDLE;
                            gnt_q       <= '0;
                            busy_q      <= 1'b0;
                            burst_cnt_q <= '0;
                        end
                    end else if (w_en) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random producers against a
// cycle-level reference model (owner / last owner / accepted-word count).
module tb_fifo_wr_arbiter;
    import fifo_wr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            full;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus4 ();
    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus1 ();

    assign bus4.req = req;  assign bus4.req_data = req_data;  assign bus4.full = full;
    assign bus1.req = req;  assign bus1.req_data = req_data;  assign bus1.full = full;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(4)) dut4 (
        .wclk(clk), .wrst_n(rst_n), .bus(bus4));
    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1), .CNT_WIDTH(1)) dut1 (
        .wclk(clk), .wrst_n(rst_n), .bus(bus1));

    // Reference model state: owner index (-1 when idle), last owner, words accepted this grant.
    int m_owner, m_last, m_cnt, m_mb;
    int sel;
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    // Packed view: {gnt[4], busy, w_en, ack[4], data_in[8]}
    logic [17:0]  obs, exp_v;
    logic [N-1:0] last_ack;

    function automatic int rr_next(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [17:0] model_out();
        logic [N-1:0]  g, a;
        logic          wen;
        logic [DW-1:0] d;
        if (m_owner < 0) return '0;
        g          = '0;
        g[m_owner] = 1'b1;
        wen        = req[m_owner] & ~full;
        a          = wen ? g : '0;
        d          = req_data[m_owner*DW +: DW];
        return {g, 1'b1, wen, a, d};
    endfunction

    function automatic logic [17:0] dut_out();
        if (sel == 1) return {bus1.gnt, bus1.busy, bus1.w_en, bus1.ack, bus1.data_in};
        return {bus4.gnt, bus4.busy, bus4.w_en, bus4.ack, bus4.data_in};
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = N - 1;
        m_cnt    = 0;
        last_ack = '0;
    endtask

    task automatic model_edge();
        bit accepted;
        if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = rr_next(req, m_last);
                m_last  = m_owner;
                m_cnt   = 0;
            end
        end else begin
            accepted = req[m_owner] && !full;
            if (accepted) m_cnt++;
            if (!req[m_owner] || (accepted && m_cnt == m_mb)) begin
                if (req != 0) begin
                    m_owner = rr_next(req, m_owner);
                    m_last  = m_owner;
                    m_cnt   = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    // One clock: sample outputs mid-cycle, advance the model at the edge, refresh acked data.
    task automatic tick();
        #1;
        exp_v = model_out();
        obs   = dut_out();
        @(posedge clk);
        model_edge();
        last_ack = exp_v[11:8];
        cyc++;
        if (exp_v[12]) $display("[TB] cyc %0d dut%0d write gnt=%b data=%h", cyc, sel, exp_v[17:14], exp_v[7:0]);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (last_ack[i]) req_data[i*DW +: DW] = 8'($urandom);
        end
    endtask

    task automatic apply_reset(input int s, input int mb);
        sel      = s;
        m_mb     = mb;
        rst_n    = 1'b0;
        req      = '0;
        full     = 1'b0;
        req_data = {$urandom, $urandom} ;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(0, 4);
        rst_n = 1'b0;
        #1;
        obs = {bus4.gnt, bus4.busy, bus4.w_en, bus4.ack, bus4.data_in};
        n_tests++;
        if (obs !== 18'h0) begin n_fail++; $display("FAIL reset_dut4 got=%h exp=%h", obs, 18'h0); end
        obs = {bus1.gnt, bus1.busy, bus1.w_en, bus1.ack, bus1.data_in};
        n_tests++;
        if (obs !== 18'h0) begin n_fail++; $display("FAIL reset_dut1 got=%h exp=%h", obs, 18'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL reset_idle c%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_single_burst();
        int acks = 0;
        apply_reset(0, 4);
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL single_burst c%0d got=%h exp=%h", c, obs, exp_v); end
            if (last_ack[0]) acks++;
            if (acks == 3) req = '0;
        end
    endtask

    task automatic test_two_burst();
        apply_reset(0, 4);
        req = 4'b0011;
        for (int c = 0; c < 14; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL two_burst c%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_full_stall();
        int acks = 0;
        apply_reset(0, 4);
        req = 4'b0100;
        for (int c = 0; c < 12 && acks < 2; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL full_pre c%0d got=%h exp=%h", c, obs, exp_v); end
            if (last_ack[2]) acks++;
        end
        full = 1'b1;
        req  = 4'b1100;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL full_stall c%0d got=%h exp=%h", c, obs, exp_v); end
        end
        full = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL full_post c%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_burst1_rr();
        apply_reset(1, 1);
        req = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL burst1_rr c%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        int acks = 0;
        apply_reset(0, 4);
        req = 4'b0010;
        for (int c = 0; c < 10 && acks < 2; c++) begin
            tick();
            if (last_ack[1]) acks++;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        obs = dut_out();
        n_tests++;
        if (obs !== 18'h0) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, 18'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL async_after c%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_handoff();
        logic [N-1:0] plan [8] = '{4'b0001, 4'b0001, 4'b1001, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001};
        apply_reset(0, 4);
        for (int c = 0; c < 12; c++) begin
            req = plan[c < 8 ? c : 7];
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL handoff c%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_random(input int s, input int mb, input int cycles);
        apply_reset(s, mb);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (last_ack[i]) begin
                        if ($urandom_range(3) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(9) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            full = ($urandom_range(3) == 0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random_mb%0d c%0d got=%h exp=%h", mb, c, obs, exp_v); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        full     = 1'b0;
        req_data = '0;
        sel      = 0;
        m_mb     = 4;
        model_reset();
        test_reset();
        test_single_burst();
        test_two_burst();
        test_full_stall();
        test_burst1_rr();
        test_async_reset();
        test_handoff();
        test_random(0, 4, 300);
        test_random(1, 1, 150);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
